// File: rtl/dma_read_requester.sv
// Splits one DMA read chunk into 4 KB-safe memory-read requests, tracks tags, writes completion DWs to device memory.
// Request out one cycle after chunk accept; write one cycle after each DW; fields hold while rd_req_ready is low.
module dma_read_requester #(
  parameter int NUM_TAGS     = 8,
  parameter int MAX_RD_BYTES = 512,
  localparam int TW          = $clog2(NUM_TAGS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          dma_pending,
  input  logic          dma_dir_write,
  input  logic [31:0]   dma_size,
  input  logic [63:0]   dma_address_host,
  input  logic [31:0]   dma_address_device,
  output logic          dma_done,
  output logic          rd_req_valid,
  input  logic          rd_req_ready,
  output logic [63:0]   rd_req_addr,
  output logic [10:0]   rd_req_len,
  output logic [TW-1:0] rd_req_tag,
  input  logic          cpl_valid,
  input  logic [TW-1:0] cpl_tag,
  input  logic [31:0]   cpl_data,
  output logic          mem_wr_en,
  output logic [31:0]   mem_wr_addr,
  output logic [31:0]   mem_wr_data,
  output logic          err_unexpected_cpl
);

  localparam logic [31:0] MAX_BYTES = 32'(MAX_RD_BYTES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CPL, DONE} state_t;

  state_t              state, state_nxt;
  logic [63:0]         host_addr;
  logic [31:0]         dev_addr;
  logic [31:0]         rem_bytes;
  logic [NUM_TAGS-1:0] busy;
  logic [31:0]         tag_dev [NUM_TAGS];
  logic [10:0]         tag_rem [NUM_TAGS];
  logic [31:0]         bnd_bytes;
  logic [31:0]         req_bytes;
  logic [TW-1:0]       free_tag;
  logic                any_free;
  logic                accept;
  logic                cpl_hit;
  logic                unused_req_bits;

  // Request size: remaining bytes, clipped to max read size and to the next 4 KB boundary.
  always_comb begin
    bnd_bytes = 32'd4096 - {20'd0, host_addr[11:0]};
    req_bytes = rem_bytes;
    if (req_bytes > MAX_BYTES) req_bytes = MAX_BYTES;
    if (req_bytes > bnd_bytes) req_bytes = bnd_bytes;
  end

  assign unused_req_bits = ^{req_bytes[31:13], req_bytes[1:0]};

  always_comb begin
    free_tag = '0;
    any_free = 1'b0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_tag = TW'(i);
        any_free = 1'b1;
      end
    end
  end

  assign rd_req_valid = (state == ISSUE) && any_free;
  assign rd_req_addr  = host_addr;
  assign rd_req_len   = req_bytes[12:2];
  assign rd_req_tag   = free_tag;
  assign accept       = rd_req_valid && rd_req_ready;
  assign cpl_hit      = cpl_valid && busy[cpl_tag];
  assign dma_done     = (state == DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (dma_pending && !dma_dir_write) state_nxt = (dma_size == 32'd0) ? DONE : ISSUE;
      ISSUE:    if (accept && (rem_bytes == req_bytes)) state_nxt = WAIT_CPL;
      WAIT_CPL: if (busy == '0) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Accept only takes a free tag and completions only touch busy tags, so the two never collide.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      host_addr          <= '0;
      dev_addr           <= '0;
      rem_bytes          <= '0;
      busy               <= '0;
      mem_wr_en          <= 1'b0;
      mem_wr_addr        <= '0;
      mem_wr_data        <= '0;
      err_unexpected_cpl <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      if (state == IDLE && dma_pending && !dma_dir_write) begin
        host_addr <= dma_address_host;
        dev_addr  <= dma_address_device;
        rem_bytes <= dma_size;
      end
      if (accept) begin
        host_addr      <= host_addr + 64'(req_bytes);
        dev_addr       <= dev_addr + req_bytes;
        rem_bytes      <= rem_bytes - req_bytes;
        busy[free_tag] <= 1'b1;
      end
      if (cpl_valid) begin
        if (cpl_hit) begin
          mem_wr_en   <= 1'b1;
          mem_wr_addr <= tag_dev[cpl_tag];
          mem_wr_data <= cpl_data;
          if (tag_rem[cpl_tag] == 11'd1) busy[cpl_tag] <= 1'b0;
        end else begin
          err_unexpected_cpl <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      tag_dev[free_tag] <= dev_addr;
      tag_rem[free_tag] <= req_bytes[12:2];
    end
    if (cpl_hit) begin
      tag_dev[cpl_tag] <= tag_dev[cpl_tag] + 32'd4;
      tag_rem[cpl_tag] <= tag_rem[cpl_tag] - 11'd1;
    end
  end

endmodule

// File: tb/tb_dma_read_requester.sv
// Scoreboard bench for dma_read_requester: stimulus pushes expected requests/writes/done cycles, a negedge monitor pops and compares.
module tb_dma_read_requester;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        dma_pending = 1'b0;
  logic        dma_dir_write = 1'b0;
  logic [31:0] dma_size = '0;
  logic [63:0] dma_address_host = '0;
  logic [31:0] dma_address_device = '0;
  logic        dma_done;
  logic        rd_req_valid;
  logic        rd_req_ready = 1'b1;
  logic [63:0] rd_req_addr;
  logic [10:0] rd_req_len;
  logic [2:0]  rd_req_tag;
  logic        cpl_valid = 1'b0;
  logic [2:0]  cpl_tag = '0;
  logic [31:0] cpl_data = '0;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        err_unexpected_cpl;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {logic [63:0] addr; logic [10:0] len; logic [2:0] tag;} req_t;
  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;

  req_t exp_req[$];
  wr_t  exp_wr[$];
  int   exp_done[$];

  dma_read_requester #(.NUM_TAGS(8), .MAX_RD_BYTES(512)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .dma_pending(dma_pending), .dma_dir_write(dma_dir_write), .dma_size(dma_size),
    .dma_address_host(dma_address_host), .dma_address_device(dma_address_device),
    .dma_done(dma_done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_req_len(rd_req_len), .rd_req_tag(rd_req_tag),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_data(cpl_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .err_unexpected_cpl(err_unexpected_cpl)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT event must match the head of its expectation queue.
  always @(negedge i_clk) begin
    req_t er;
    wr_t  ew;
    int   ed;
    if (!i_rst && rd_req_valid && rd_req_ready) begin
      if (exp_req.size() == 0) begin
        checks++; failures++;
        $display("FAIL req_unexpected: got request addr %0h len %0d tag %0d, expected none", rd_req_addr, rd_req_len, rd_req_tag);
      end else begin
        er = exp_req.pop_front();
        chk("req", 96'({rd_req_addr, rd_req_len, rd_req_tag}), 96'(er));
      end
    end
    if (mem_wr_en) begin
      if (exp_wr.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected: got write addr %0h data %0h, expected none", mem_wr_addr, mem_wr_data);
      end else begin
        ew = exp_wr.pop_front();
        chk("mem_wr", 96'({mem_wr_addr, mem_wr_data}), 96'(ew));
      end
    end
    if (dma_done) begin
      if (exp_done.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected: got dma_done at cycle %0d, expected none", cyc);
      end else begin
        ed = exp_done.pop_front();
        chk("done_cycle", 96'(cyc), 96'(ed));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // One-cycle chunk offer; returns in the cycle after dma_pending was sampled.
  task automatic start(input logic dir, input logic [31:0] size, input logic [63:0] host, input logic [31:0] dev);
    tick();
    dma_pending = 1'b1; dma_dir_write = dir; dma_size = size;
    dma_address_host = host; dma_address_device = dev;
    if (size == 32'd0 && !dir) exp_done.push_back(cyc + 1);
    tick();
    dma_pending = 1'b0;
  endtask

  task automatic dw(input logic [2:0] tag, input logic [31:0] data, input logic [31:0] waddr, input bit expect_wr);
    tick();
    cpl_valid = 1'b1; cpl_tag = tag; cpl_data = data;
    if (expect_wr) exp_wr.push_back({waddr, data});
  endtask

  task automatic dw_off();
    tick();
    cpl_valid = 1'b0;
  endtask

  task automatic burst(input logic [2:0] tag, input int n, input logic [31:0] dev, input logic [31:0] seed);
    for (int i = 0; i < n; i++) dw(tag, seed + 32'(i), dev + 32'(4 * i), 1'b1);
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_outputs", 96'({rd_req_valid, dma_done, mem_wr_en, err_unexpected_cpl}), 96'd0);
    chk("rst_req_fields", 96'({rd_req_addr, rd_req_len, rd_req_tag}), 96'd0);
    chk("rst_wr_fields", 96'({mem_wr_addr, mem_wr_data}), 96'd0);
    i_rst = 1'b0;

    // Single aligned 256-byte chunk
    exp_req.push_back({64'h1000, 11'd64, 3'd0});
    start(1'b0, 32'd256, 64'h1000, 32'h0);
    chk("req_start_valid", 96'(rd_req_valid), 96'd1);
    idle(2);
    burst(3'd0, 64, 32'h0, 32'hA000_0000);
    exp_done.push_back(cyc + 2);
    dw_off();
    idle(4);

    // Chunk straddling 4 KB boundary
    exp_req.push_back({64'h0FC0, 11'd16, 3'd0});
    exp_req.push_back({64'h1000, 11'd48, 3'd1});
    start(1'b0, 32'd256, 64'h0FC0, 32'h2000);
    idle(2);
    burst(3'd0, 16, 32'h2000, 32'hB000_0000);
    burst(3'd1, 48, 32'h2040, 32'hB100_0000);
    exp_done.push_back(cyc + 2);
    dw_off();
    idle(4);

    // Interleaved completions for two tags
    exp_req.push_back({64'h1FE0, 11'd8, 3'd0});
    exp_req.push_back({64'h2000, 11'd8, 3'd1});
    start(1'b0, 32'd64, 64'h1FE0, 32'h100);
    idle(2);
    for (int i = 0; i < 8; i++) begin
      dw(3'd1, 32'hC100_0000 + 32'(i), 32'h120 + 32'(4 * i), 1'b1);
      dw(3'd0, 32'hC000_0000 + 32'(i), 32'h100 + 32'(4 * i), 1'b1);
    end
    exp_done.push_back(cyc + 2);
    dw_off();
    idle(4);

    // Device address wraps modulo 2^32
    exp_req.push_back({64'h3000, 11'd4, 3'd0});
    start(1'b0, 32'd16, 64'h3000, 32'hFFFF_FFF8);
    idle(2);
    dw(3'd0, 32'hD000_0000, 32'hFFFF_FFF8, 1'b1);
    dw(3'd0, 32'hD000_0001, 32'hFFFF_FFFC, 1'b1);
    dw(3'd0, 32'hD000_0002, 32'h0000_0000, 1'b1);
    dw(3'd0, 32'hD000_0003, 32'h0000_0004, 1'b1);
    exp_done.push_back(cyc + 2);
    dw_off();
    idle(4);

    // Tag exhaustion, backpressure hold, and tag reuse one cycle after free
    rd_req_ready = 1'b0;
    for (int k = 0; k < 8; k++) exp_req.push_back({64'(k * 512), 11'd128, 3'(k)});
    exp_req.push_back({64'h1000, 11'd128, 3'd0});
    start(1'b0, 32'd4608, 64'h0, 32'h8000_0000);
    for (int j = 0; j < 3; j++) begin
      chk("bp_hold", 96'({rd_req_valid, rd_req_addr, rd_req_len, rd_req_tag}), 96'({1'b1, 64'h0, 11'd128, 3'd0}));
      tick();
    end
    rd_req_ready = 1'b1;
    idle(10);
    chk("tags_exhausted_valid", 96'(rd_req_valid), 96'd0);
    burst(3'd0, 128, 32'h8000_0000, 32'hE000_0000);
    chk("tag_not_free_early", 96'(rd_req_valid), 96'd0);
    dw_off();
    chk("tag_reuse", 96'({rd_req_valid, rd_req_addr, rd_req_len, rd_req_tag}), 96'({1'b1, 64'h1000, 11'd128, 3'd0}));
    for (int k = 1; k < 8; k++) burst(3'(k), 128, 32'h8000_0000 + 32'(k * 512), 32'hE000_0000 + 32'(k << 16));
    burst(3'd0, 128, 32'h8000_1000, 32'hE800_0000);
    exp_done.push_back(cyc + 2);
    dw_off();
    idle(4);

    // Write-direction chunk ignored; zero-size read completes immediately
    start(1'b1, 32'd256, 64'h7000, 32'h0);
    chk("dir_write_ignored", 96'(rd_req_valid), 96'd0);
    idle(5);
    start(1'b0, 32'd0, 64'h8000, 32'h0);
    chk("zero_size_no_req", 96'(rd_req_valid), 96'd0);
    idle(3);

    // Reset mid-chunk: no done, stale completion flags the error
    exp_req.push_back({64'h5000, 11'd16, 3'd0});
    start(1'b0, 32'd64, 64'h5000, 32'h0);
    idle(2);
    i_rst = 1'b1;
    idle(2);
    i_rst = 1'b0;
    dw(3'd0, 32'h1234_5678, 32'h0, 1'b0);
    dw_off();
    chk("stale_tag_no_write", 96'(mem_wr_en), 96'd0);
    chk("stale_tag_err", 96'(err_unexpected_cpl), 96'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("err_cleared_by_rst", 96'(err_unexpected_cpl), 96'd0);

    // Completion on a free tag
    dw(3'd3, 32'hDEAD_BEEF, 32'h0, 1'b0);
    dw_off();
    chk("free_tag_no_write", 96'(mem_wr_en), 96'd0);
    chk("free_tag_err", 96'(err_unexpected_cpl), 96'd1);
    idle(5);
    chk("err_sticky", 96'(err_unexpected_cpl), 96'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("err_reset", 96'(err_unexpected_cpl), 96'd0);

    idle(3);
    chk("req_queue_drained", 96'(exp_req.size()), 96'd0);
    chk("wr_queue_drained", 96'(exp_wr.size()), 96'd0);
    chk("done_queue_drained", 96'(exp_done.size()), 96'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
